// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type, default sizes and parity helper for data_mem_bank
package dmem_pkg;
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam int DMEM_DATA_W_DEF = 8;
  localparam int DMEM_DEPTH_DEF = 16;
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/data_mem_bank_if.sv
// data_mem_bank_if: write/read/clear bus of data_mem_bank (master = requester, slave = memory)
interface data_mem_bank_if import dmem_pkg::*; #(
  parameter int DATA_W = DMEM_DATA_W_DEF,
  parameter int DEPTH = DMEM_DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic clear_req, wr_en, rd_req, rd_valid, busy, par_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  modport master(output clear_req, wr_en, wr_addr, wr_data, rd_req, rd_addr, input rd_data, rd_valid, busy, par_err);
  modport slave(input clear_req, wr_en, wr_addr, wr_data, rd_req, rd_addr, output rd_data, rd_valid, busy, par_err);
endinterface

// File: rtl/dmem_clear_seq.sv
// dmem_clear_seq: CLEAR/IDLE sequencer walking clr_ptr over every word after reset or clear_req
module dmem_clear_seq import dmem_pkg::*; #(
  parameter int DEPTH = DMEM_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_req,
  output logic busy,
  output logic clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_addr
);
  localparam int ADDR_W = $clog2(DEPTH);
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end
  always_comb begin
    state_nx = state == CLEAR ? (clr_ptr == ADDR_W'(DEPTH - 1) ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
    clr_ptr_nx = state == CLEAR ? clr_ptr + ADDR_W'(1) : '0;
  end
  assign busy = state == CLEAR;
  assign clr_we = busy;
  assign clr_addr = clr_ptr;
endmodule

// File: rtl/data_mem_bank.sv
// data_mem_bank: 1W1R synchronous data memory with registered read, sequenced clear, optional DMEM_PARITY_EN parity
module data_mem_bank import dmem_pkg::*; #(
  parameter int DATA_W = DMEM_DATA_W_DEF,
  parameter int DEPTH = DMEM_DEPTH_DEF,
  parameter bit WRITE_FIRST = 1'b1
) (
  input logic clk,
  input logic reset,
  data_mem_bank_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef DMEM_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif
  logic busy, clr_we, we, rd_fire, fwd, par_bad;
  logic [ADDR_W-1:0] clr_addr, waddr;
  logic [W-1:0] wword, rword;
  logic [W-1:0] mem [DEPTH];
  dmem_clear_seq #(.DEPTH(DEPTH)) u_clear (
    .clk(clk),
    .reset(reset),
    .clear_req(bus.clear_req),
    .busy(busy),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  always_comb begin
    we = busy ? clr_we : bus.wr_en;
    waddr = busy ? clr_addr : bus.wr_addr;
    rd_fire = !busy && bus.rd_req;
    fwd = WRITE_FIRST && bus.wr_en && bus.wr_addr == bus.rd_addr;
    rword = mem[bus.rd_addr];
`ifdef DMEM_PARITY_EN
    wword = busy ? '0 : {even_par(64'(bus.wr_data)), bus.wr_data};
    par_bad = rword[DATA_W] != even_par(64'(rword[DATA_W-1:0]));
`else
    wword = busy ? '0 : bus.wr_data;
    par_bad = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wword;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      bus.par_err <= 1'b0;
    end else begin
      bus.rd_valid <= rd_fire;
      bus.par_err <= rd_fire && !fwd && par_bad;
      if (rd_fire) bus.rd_data <= fwd ? bus.wr_data : rword[DATA_W-1:0];
    end
  end
  assign bus.busy = busy;
endmodule

// File: tb/tb_data_mem_bank.sv
// tb_data_mem_bank: directed self-checking bench for data_mem_bank
module tb_data_mem_bank;
  import dmem_pkg::*;
  parameter int DATA_W = DMEM_DATA_W_DEF;
  parameter int DEPTH = DMEM_DEPTH_DEF;
  parameter bit WRITE_FIRST = 1'b1;
  localparam int ADDR_W = $clog2(DEPTH);
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int n, seen;
  always #5 clk = ~clk;
  data_mem_bank_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus();
  data_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WRITE_FIRST(WRITE_FIRST)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input string tag, input int a, input logic [DATA_W-1:0] exp);
    bus.rd_req = 1'b1;
    bus.rd_addr = ADDR_W'(a);
    @(negedge clk);
    bus.rd_req = 1'b0;
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'(1));
    check({tag, "_data"}, 64'(bus.rd_data), 64'(exp));
    check({tag, "_perr"}, 64'(bus.par_err), 64'(0));
    @(negedge clk);
    check({tag, "_drop"}, 64'(bus.rd_valid), 64'(0));
  endtask
  task automatic busy_len(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 4 * DEPTH) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic preload(input logic [DATA_W-1:0] d);
    for (int i = 0; i < DEPTH; i++) dut.mem[i] = d;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.clear_req = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    busy_len(n);
    check("init_clear_len", 64'(n), 64'(DEPTH));
    preload('hA5);
    rd("pre_rd", 1, 'hA5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'(1));
    check("rst_valid", 64'(bus.rd_valid), 64'(0));
    check("rst_data", 64'(bus.rd_data), 64'(0));
    check("rst_perr", 64'(bus.par_err), 64'(0));
    busy_len(n);
    check("rst_clear_len", 64'(n), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) rd("clr_word", i, '0);
    wr(5, 'h3C);
    wr(6, 'hC3);
    bus.rd_req = 1'b1;
    bus.rd_addr = ADDR_W'(5);
    @(negedge clk);
    check("b2b0_valid", 64'(bus.rd_valid), 64'(1));
    check("b2b0_data", 64'(bus.rd_data), 64'('h3C));
    bus.rd_addr = ADDR_W'(6);
    @(negedge clk);
    bus.rd_req = 1'b0;
    check("b2b1_valid", 64'(bus.rd_valid), 64'(1));
    check("b2b1_data", 64'(bus.rd_data), 64'('hC3));
    @(negedge clk);
    check("b2b_end_valid", 64'(bus.rd_valid), 64'(0));
    check("b2b_hold_data", 64'(bus.rd_data), 64'('hC3));
    wr(9, 'h11);
    bus.wr_en = 1'b1;
    bus.wr_addr = ADDR_W'(9);
    bus.wr_data = 'h22;
    bus.rd_req = 1'b1;
    bus.rd_addr = ADDR_W'(9);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_req = 1'b0;
    check("coll_valid", 64'(bus.rd_valid), 64'(1));
    check("coll_data", 64'(bus.rd_data), WRITE_FIRST ? 64'('h22) : 64'('h11));
    check("coll_perr", 64'(bus.par_err), 64'(0));
    @(negedge clk);
    rd("coll_after", 9, 'h22);
    bus.clear_req = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_addr = ADDR_W'(5);
    @(negedge clk);
    check("clrreq_rd_valid", 64'(bus.rd_valid), 64'(1));
    check("clrreq_rd_data", 64'(bus.rd_data), 64'('h3C));
    check("clrreq_busy", 64'(bus.busy), 64'(1));
    bus.wr_en = 1'b1;
    bus.wr_addr = ADDR_W'(2);
    bus.wr_data = 'hFF;
    bus.rd_addr = ADDR_W'(2);
    n = 0;
    seen = 0;
    while (bus.busy && n < 4 * DEPTH) begin
      @(negedge clk);
      n++;
      if (bus.rd_valid) seen++;
    end
    bus.clear_req = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_req = 1'b0;
    check("clrreq_len", 64'(n), 64'(DEPTH));
    check("clr_no_valid", 64'(seen), 64'(0));
    rd("clr_drop_wr", 2, '0);
    rd("clr_zero5", 5, '0);
    preload('hA5);
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 64'(bus.busy), 64'(1));
    busy_len(n);
    check("mid_rst_len", 64'(n), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) rd("mid_rst_word", i, '0);
    wr(3, 'h0F);
    rd("par_clean", 3, 'h0F);
    dut.mem[3][0] = ~dut.mem[3][0];
    bus.rd_req = 1'b1;
    bus.rd_addr = ADDR_W'(3);
    @(negedge clk);
    bus.rd_req = 1'b0;
    check("par_flip_valid", 64'(bus.rd_valid), 64'(1));
    check("par_flip_data", 64'(bus.rd_data), 64'('h0E));
`ifdef DMEM_PARITY_EN
    check("par_flip_err", 64'(bus.par_err), 64'(1));
`else
    check("par_flip_err", 64'(bus.par_err), 64'(0));
`endif
    @(negedge clk);
    check("par_err_drop", 64'(bus.par_err), 64'(0));
    rd("par_other", 5, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
